// File: rtl/pb_conditioner_pkg.sv
// Shared types and default parameters for the push-button conditioner.
// The repeat FSM state type lives here so that the channel and any debug logic agree on it.
package pb_conditioner_pkg;

  localparam int DEF_NUM_BUTTONS  = 4;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_DEBOUNCE_LEN = 10;
  localparam int DEF_HOLD_TICKS   = 500;
  localparam int DEF_REPEAT_TICKS = 100;

  typedef enum logic [1:0] {
    PB_IDLE,
    PB_HOLD,
    PB_REPEAT
  } pb_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One push-button: 2-flop synchronizer, tick-sampled debounce with hysteresis,
// registered press/release edge pulses and an auto-repeat FSM driven by the shared tick.
module pb_channel
  import pb_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_LEN = DEF_DEBOUNCE_LEN,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic resetn,
  input  logic pb_n,
  input  logic tick,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS) + 1);

  logic                    sync_meta;
  logic                    sync;
  logic [DEBOUNCE_LEN-1:0] shift;
  logic                    level_d;
  pb_state_t               state;
  logic [CNT_W-1:0]        tick_cnt;
  logic [CNT_W-1:0]        cnt_inc;

  assign cnt_inc = tick_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_meta     <= 1'b0;
      sync          <= 1'b0;
      shift         <= '0;
      level         <= 1'b0;
      level_d       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      state         <= PB_IDLE;
      tick_cnt      <= '0;
    end else begin
      sync_meta <= ~pb_n;
      sync      <= sync_meta;
      if (tick) begin
        shift <= {shift[DEBOUNCE_LEN-2:0], sync};
      end
      // Mixed history keeps the previous level, so short glitches are absorbed.
      if (&shift) begin
        level <= 1'b1;
      end else if (~|shift) begin
        level <= 1'b0;
      end
      level_d       <= level;
      press_pulse   <= level & ~level_d;
      release_pulse <= ~level & level_d;
      repeat_pulse  <= 1'b0;

      if (release_pulse) begin
        state    <= PB_IDLE;
        tick_cnt <= '0;
      end else begin
        case (state)
          PB_IDLE: begin
            tick_cnt <= '0;
            if (press_pulse) begin
              state <= PB_HOLD;
            end
          end
          PB_HOLD: begin
            if (tick) begin
              if (cnt_inc == CNT_W'(HOLD_TICKS)) begin
                repeat_pulse <= 1'b1;
                tick_cnt     <= '0;
                state        <= PB_REPEAT;
              end else begin
                tick_cnt <= cnt_inc;
              end
            end
          end
          PB_REPEAT: begin
            if (tick) begin
              if (cnt_inc == CNT_W'(REPEAT_TICKS)) begin
                repeat_pulse <= 1'b1;
                tick_cnt     <= '0;
              end else begin
                tick_cnt <= cnt_inc;
              end
            end
          end
          default: begin
            state    <= PB_IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/pb_conditioner.sv
// Push-button front end: one shared sampling-tick divider feeding NUM_BUTTONS
// independent debounce/edge/auto-repeat channels.
module pb_conditioner
  import pb_conditioner_pkg::*;
#(
  parameter int NUM_BUTTONS  = DEF_NUM_BUTTONS,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int DEBOUNCE_LEN = DEF_DEBOUNCE_LEN,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic                   CLOCK_50_I,
  input  logic                   resetn,
  input  logic [NUM_BUTTONS-1:0] PUSH_BUTTON_N_I,
  output logic                   tick_o,
  output logic [NUM_BUTTONS-1:0] pb_level_o,
  output logic [NUM_BUTTONS-1:0] pb_press_o,
  output logic [NUM_BUTTONS-1:0] pb_release_o,
  output logic [NUM_BUTTONS-1:0] pb_repeat_o
);

  localparam int DIV_W = $clog2(TICK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;

  assign div_last = (div_cnt == DIV_W'(TICK_DIV - 1));

  // tick_o is high for the cycle after the divider sits at its terminal count.
  always_ff @(posedge CLOCK_50_I) begin
    if (!resetn) begin
      div_cnt <= '0;
      tick_o  <= 1'b0;
    end else begin
      tick_o  <= div_last;
      div_cnt <= div_last ? '0 : div_cnt + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_channel
      pb_channel #(
        .DEBOUNCE_LEN (DEBOUNCE_LEN),
        .HOLD_TICKS   (HOLD_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
      ) u_channel (
        .clk           (CLOCK_50_I),
        .resetn        (resetn),
        .pb_n          (PUSH_BUTTON_N_I[gi]),
        .tick          (tick_o),
        .level         (pb_level_o[gi]),
        .press_pulse   (pb_press_o[gi]),
        .release_pulse (pb_release_o[gi]),
        .repeat_pulse  (pb_repeat_o[gi])
      );
    end
  endgenerate

endmodule
